// File: rtl/weight_bit_serializer_if.sv
// Handshake bundle between weight/activation fetch, the bit serializer and the bit-serial MAC.
// Purely structural: carries the parallel word in and the framed serial stream out.
interface weight_bit_serializer_if #(
  parameter int W_MAX     = 8,
  parameter int ACT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W_MAX-1:0]     in_w;
  logic [ACT_WIDTH-1:0] in_act;
  logic [3:0]           in_prec;
  logic                 out_ready;
  logic                 valid;
  logic                 w;
  logic [ACT_WIDTH-1:0] act;
  logic [3:0]           precision;
  logic                 first;
  logic                 last;

  modport master (
    output in_valid, in_w, in_act, in_prec, out_ready,
    input  in_ready, valid, w, act, precision, first, last
  );

  modport slave (
    input  in_valid, in_w, in_act, in_prec, out_ready,
    output in_ready, valid, w, act, precision, first, last
  );
endinterface

// File: rtl/weight_bit_serializer.sv
// 2-deep FIFO of {weight, activation, precision} feeding an MSB-first shifter; MSB appears 2 cycles after push.
// out_ready low freezes every output and blocks pops; in_ready drops when both FIFO entries are full.
module weight_bit_serializer #(
  parameter int W_MAX     = 8,
  parameter int ACT_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  weight_bit_serializer_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [W_MAX-1:0]     w;
    logic [ACT_WIDTH-1:0] act;
    logic [3:0]           prec;
  } entry_t;

  entry_t               fifo_q [2];
  entry_t               fifo_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [W_MAX-1:0]     shreg_q, shreg_d;
  logic                 valid_q, valid_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;
  logic [ACT_WIDTH-1:0] act_q, act_d;
  logic [3:0]           prec_q, prec_d;

  logic                 push;
  logic                 pop;
  logic                 consume;
  logic [3:0]           prec_clamped;
  entry_t               head;

  assign prec_clamped = (bus.in_prec == 4'd0 || bus.in_prec > 4'(W_MAX)) ? 4'(W_MAX) : bus.in_prec;
  assign bus.in_ready = (count_q != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign consume      = valid_q && bus.out_ready;
  assign head         = fifo_q[rd_ptr_q];
  // Pop only when the shifter is free or is handing over its last bit this cycle.
  assign pop          = (count_q != 2'd0) && bus.out_ready &&
                        ((state_q == IDLE) || (valid_q && last_q));

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    valid_d  = valid_q;
    first_d  = first_q;
    last_d   = last_q;
    act_d    = act_q;
    prec_d   = prec_q;

    if (push) begin
      fifo_d[wr_ptr_q] = '{w: bus.in_w, act: bus.in_act, prec: prec_clamped};
      wr_ptr_d         = ~wr_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      state_d  = SHIFT;
      cnt_d    = 4'd0;
      // Left-align the word so the MSB sits at the top; unused high bits fall off.
      shreg_d  = head.w << (4'(W_MAX) - head.prec);
      valid_d  = 1'b1;
      first_d  = 1'b1;
      last_d   = (head.prec == 4'd1);
      act_d    = head.act;
      prec_d   = head.prec;
    end else if (consume) begin
      if (last_q) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        shreg_d = '0;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        cnt_d   = cnt_q + 4'd1;
        shreg_d = shreg_q << 1;
        first_d = 1'b0;
        last_d  = ((cnt_q + 4'd1) == (prec_q - 4'd1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      shreg_q  <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      act_q    <= '0;
      prec_q   <= 4'd0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      act_q    <= act_d;
      prec_q   <= prec_d;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.w         = shreg_q[W_MAX-1];
  assign bus.first     = first_q;
  assign bus.last      = last_q;
  assign bus.act       = act_q;
  assign bus.precision = prec_q;
endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed and randomized checks of the weight serializer against a word-to-bit-list reference model.
module tb_weight_bit_serializer;
  localparam int W_MAX     = 8;
  localparam int ACT_WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  weight_bit_serializer_if #(.W_MAX(W_MAX), .ACT_WIDTH(ACT_WIDTH)) bus ();
  weight_bit_serializer #(.W_MAX(W_MAX), .ACT_WIDTH(ACT_WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic                 w;
    logic                 first;
    logic                 last;
    logic [ACT_WIDTH-1:0] act;
    logic [3:0]           prec;
  } bit_t;

  bit_t exp_q[$];
  logic obs_hist[$];
  int   run_len = 0;
  int   last_run = 0;
  int   acc_cnt = 0;
  bit   rand_ready = 0;
  logic prev_stall = 0, prev_vld = 0;
  logic prev_w, prev_first, prev_last;
  logic [ACT_WIDTH-1:0] prev_act;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a word of precision p becomes p bits, sign first, framed by first/last.
  task automatic model_push(input logic [W_MAX-1:0] wv, input logic [ACT_WIDTH-1:0] av, input logic [3:0] pr);
    int p;
    p = (pr == 4'd0 || int'(pr) > W_MAX) ? W_MAX : int'(pr);
    for (int i = p - 1; i >= 0; i--)
      exp_q.push_back('{wv[i], (i == p - 1), (i == 0), av, 4'(p)});
  endtask

  task automatic sample();
    bit_t e;
    if (rst) begin
      exp_q.delete();
      run_len = 0;
      prev_stall = 0;
      prev_vld = 0;
      return;
    end
    if (prev_stall) begin
      check("stall_hold_valid", bus.valid, 1);
      check("stall_hold_w", bus.w, prev_w);
      check("stall_hold_first", bus.first, prev_first);
      check("stall_hold_last", bus.last, prev_last);
      check("stall_hold_act", bus.act, prev_act);
    end
    if (bus.valid && prev_vld && !bus.first) check("act_stable_in_word", bus.act, prev_act);
    if (!bus.valid) check("w_zero_when_idle", bus.w, 0);
    if (bus.valid && bus.out_ready) begin
      check("bit_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream_w", bus.w, e.w);
        check("stream_first", bus.first, e.first);
        check("stream_last", bus.last, e.last);
        check("stream_act", bus.act, e.act);
        check("stream_prec", bus.precision, e.prec);
      end
      obs_hist.push_back(bus.w);
    end
    if (bus.valid) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
    if (bus.in_valid && bus.in_ready) begin
      model_push(bus.in_w, bus.in_act, bus.in_prec);
      acc_cnt++;
    end
    prev_vld   = bus.valid;
    prev_stall = bus.valid && !bus.out_ready;
    prev_w     = bus.w;
    prev_first = bus.first;
    prev_last  = bus.last;
    prev_act   = bus.act;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_word(input logic [W_MAX-1:0] wv, input logic [ACT_WIDTH-1:0] av, input logic [3:0] pr);
    logic accepted;
    logic rdy;
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_w     = wv;
    bus.in_act   = av;
    bus.in_prec  = pr;
    for (int n = 0; n < 100; n++) begin
      rdy = bus.in_ready;
      step();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("push_accepted", accepted, 1);
  endtask

  task automatic drain();
    rand_ready = 0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() == 0 && !bus.valid) break;
      step();
    end
    step();
    check("drain_model_empty", exp_q.size(), 0);
    check("drain_valid_low", bus.valid, 0);
  endtask

  // Called right after the accepting edge of a lone word into an idle serializer.
  task automatic check_bits(input logic [W_MAX-1:0] bits, input int n, input logic [ACT_WIDTH-1:0] av,
                            input logic [3:0] pr);
    check("latency_gap_valid", bus.valid, 0);
    step();
    for (int i = 0; i < n; i++) begin
      check("word_valid", bus.valid, 1);
      check("word_w", bus.w, bits[n - 1 - i]);
      check("word_first", bus.first, (i == 0));
      check("word_last", bus.last, (i == n - 1));
      check("word_act", bus.act, av);
      check("word_precision", bus.precision, pr);
      step();
    end
    check("word_end_valid", bus.valid, 0);
  endtask

  function automatic logic [31:0] get_bits(input int base);
    logic [31:0] v;
    v = '0;
    for (int i = base; i < obs_hist.size(); i++) v = {v[30:0], obs_hist[i]};
    return v;
  endfunction

  initial begin
    int base;
    int acc0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_w = '0;
    bus.in_act = '0;
    bus.in_prec = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.valid, 0);
    check("rst_w", bus.w, 0);
    check("rst_first", bus.first, 0);
    check("rst_last", bus.last, 0);
    check("rst_act", bus.act, 0);
    check("rst_precision", bus.precision, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    step();

    // Single word
    push_word(8'h05, 16'h4569, 4'd4);
    check_bits(8'h05, 4, 16'h4569, 4'd4);
    drain();
    check("single_run_len", last_run, 4);

    // Back-to-back
    base = obs_hist.size();
    push_word(8'h05, 16'h4569, 4'd4);
    push_word(8'h0A, 16'h4AAA, 4'd4);
    push_word(8'h03, 16'h4821, 4'd4);
    check("b2b_in_ready_full", bus.in_ready, 0);
    drain();
    check("b2b_bits", get_bits(base), 32'h5A3);
    check("b2b_run_len", last_run, 12);

    // Precision extremes
    push_word(8'h01, 16'h3C00, 4'd1);
    check_bits(8'h01, 1, 16'h3C00, 4'd1);
    drain();
    push_word(8'h96, 16'h1234, 4'd8);
    check_bits(8'h96, 8, 16'h1234, 4'd8);
    drain();
    push_word(8'h96, 16'h5678, 4'd0);
    check_bits(8'h96, 8, 16'h5678, 4'd8);
    drain();

    // Stall on bit 2
    base = obs_hist.size();
    push_word(8'h0A, 16'h4AAA, 4'd4);
    step();
    check("stall_bit1_w", bus.w, 1);
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_w", bus.w, 0);
      check("stall_valid", bus.valid, 1);
      check("stall_first", bus.first, 0);
      step();
    end
    bus.out_ready = 1'b1;
    check("stall_release_w", bus.w, 0);
    step();
    check("stall_bit3_w", bus.w, 1);
    step();
    check("stall_bit4_w", bus.w, 0);
    check("stall_bit4_last", bus.last, 1);
    drain();
    check("stall_bits", get_bits(base), 32'hA);
    check("stall_run_len", last_run, 7);

    // FIFO full
    base = obs_hist.size();
    acc0 = acc_cnt;
    bus.out_ready = 1'b0;
    push_word(8'h05, 16'h4569, 4'd4);
    push_word(8'h0A, 16'h4AAA, 4'd4);
    bus.in_valid = 1'b1;
    bus.in_w = 8'h03;
    bus.in_act = 16'h4821;
    bus.in_prec = 4'd4;
    for (int k = 0; k < 3; k++) begin
      check("full_in_ready", bus.in_ready, 0);
      check("full_no_load", bus.valid, 0);
      step();
    end
    check("full_accepted_two", acc_cnt - acc0, 2);
    bus.out_ready = 1'b1;
    push_word(8'h03, 16'h4821, 4'd4);
    drain();
    check("full_bits_in_order", get_bits(base), 32'h5A3);
    check("full_accepted_three", acc_cnt - acc0, 3);

    // Reset mid-word
    push_word(8'h05, 16'h4569, 4'd4);
    push_word(8'h0A, 16'h4AAA, 4'd4);
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrst_valid", bus.valid, 0);
    check("midrst_w", bus.w, 0);
    check("midrst_act", bus.act, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_bits", bus.valid, 0);
      step();
    end

    // Randomized traffic
    rand_ready = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) step();
      push_word(W_MAX'($urandom), ACT_WIDTH'($urandom), 4'($urandom_range(0, 15)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
